// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
//   Successive-approximation search controller. It drives the `b` side of an
//   N-bit magnitude comparator with a trial value and recovers the unknown
//   value on the comparator's `a` side, MSB first, in at most N compare cycles.
//
// Handshake: `start` is a level request. It is sampled only while the
//   controller is idle (busy=0, done=0). A sample of start=1 in idle launches
//   one search. `start` is ignored while busy and during the done cycle, and
//   nothing is queued. `done` pulses for one cycle when the search ends, and
//   `result`/`err` are valid from that cycle until the next accepted start.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a new search
//   cmp_greater  comparator flag: target > trial
//   cmp_small    comparator flag: target < trial
//   cmp_equal    comparator flag: target == trial
//   trial        value driven to the comparator `b` input
//   busy         high while a search is in progress
//   done         one-cycle completion pulse
//   result       recovered value
//   err          inconsistent comparator flags were seen
//   dbg_state    current FSM state (0 idle, 1 run, 2 done)
// ---------------------------------------------------------------------------
module sar_search #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_greater,
  input  logic         cmp_small,
  input  logic         cmp_equal,
  output logic [N-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N-1:0] MSB_ONE = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [N-1:0] acc;
  logic [N-1:0] mask;
  logic [N-1:0] result_q;
  logic         err_q;
  logic [2:0]   flags;

  // Trial is a pure function of registered state, so the comparator sees a
  // stable value for the whole cycle.
  assign trial     = (state == ST_RUN) ? (acc | mask) : '0;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign dbg_state = state;
  assign flags     = {cmp_greater, cmp_small, cmp_equal};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      mask     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            mask  <= MSB_ONE;
            err_q <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          case (flags)
            3'b001: begin
              // Exact hit: stop early, the trial is the answer.
              result_q <= acc | mask;
              state    <= ST_DONE;
            end
            3'b100: begin
              if (mask[0]) begin
                // Target above acc|1 cannot happen with a sane comparator.
                err_q    <= 1'b1;
                result_q <= acc | LSB_ONE;
                state    <= ST_DONE;
              end else begin
                acc  <= acc | mask;
                mask <= mask >> 1;
              end
            end
            3'b010: begin
              if (mask[0]) begin
                // Target below acc|1 while acc <= target: target is acc.
                result_q <= acc;
                state    <= ST_DONE;
              end else begin
                mask <= mask >> 1;
              end
            end
            default: begin
              // Flags not one-hot: report what has been resolved so far.
              err_q    <= 1'b1;
              result_q <= acc;
              state    <= ST_DONE;
            end
          endcase
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  localparam int N = 4;
  // Packed expectation: {run_idx[2:0], busy, done, err, trial[N-1:0], result[N-1:0]}
  localparam int W = 6 + 2 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic         cmp_greater, cmp_small, cmp_equal;
  logic [N-1:0] trial, result;
  logic         busy, done, err;
  logic [1:0]   dbg_state;

  logic [N-1:0] target = '0;
  logic         force_low = 1'b0;
  int           inj_cur = 0;

  // Ideal comparator, with an override that drops all three flags.
  assign cmp_greater = !force_low && (target > trial);
  assign cmp_small   = !force_low && (target < trial);
  assign cmp_equal   = !force_low && (target == trial);

  sar_search #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_greater(cmp_greater), .cmp_small(cmp_small), .cmp_equal(cmp_equal),
    .trial(trial), .busy(busy), .done(done), .result(result), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] held_r = '0;
  logic         held_e = 1'b0;
  int           exp_k = 0;
  int           busy_cnt = 0;
  logic [N-1:0] trial_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] idx, input logic b, input logic d,
                                      input logic e, input logic [N-1:0] t, input logic [N-1:0] r);
    return {idx, b, d, e, t, r};
  endfunction

  // Behavioural model: the search walks bit positions from the top. Before
  // examining bit j, the known part of the answer is the target with all bits
  // at and below j cleared; the trial adds 2**j to it.
  task automatic build(input logic [N-1:0] tgt, input int inj);
    int acc_v;
    int tr;
    int j;
    for (int i = 1; i <= N; i++) begin
      j = N - i;
      acc_v = (int'(tgt) / (2 ** (j + 1))) * (2 ** (j + 1));
      tr = acc_v + 2 ** j;
      exp_q.push_back(mk(i[2:0], 1'b1, 1'b0, 1'b0, tr[N-1:0], held_r));
      if (i == inj) begin
        exp_q.push_back(mk(3'd0, 1'b0, 1'b1, 1'b1, '0, acc_v[N-1:0]));
        exp_k = i;
        return;
      end
      if (tr == int'(tgt) || j == 0) begin
        exp_q.push_back(mk(3'd0, 1'b0, 1'b1, 1'b0, '0, tgt));
        exp_k = i;
        return;
      end
    end
  endtask

  // Model advance: each edge retires the cycle that just ended; a start is
  // only taken when the cycle that ended was idle.
  always @(posedge clk or posedge rst) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete();
      held_r = '0;
      held_e = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[2*N+1]) begin
        held_r = e[N-1:0];
        held_e = e[2*N];
      end
    end else if (start) begin
      build(target, inj_cur);
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) e = exp_q[0];
    else e = mk(3'd0, 1'b0, 1'b0, held_e, '0, held_r);
    chk("trial",  32'(trial),  32'(e[2*N-1:N]));
    chk("busy",   32'(busy),   32'(e[2*N+2]));
    chk("done",   32'(done),   32'(e[2*N+1]));
    chk("result", 32'(result), 32'(e[N-1:0]));
    chk("err",    32'(err),    32'(e[2*N]));
    force_low = (exp_q.size() > 0) && (inj_cur != 0) && (int'(e[W-1:W-3]) == inj_cur);
    if (rst) busy_cnt = 0;
    else begin
      if (busy) begin
        busy_cnt++;
        trial_log.push_back(trial);
      end
      if (done) begin
        chk("run_cycles", 32'(busy_cnt), 32'(exp_k));
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=timeout expected=idle at %0t", $time);
    end
  endtask

  // Called at a falling edge while idle.
  task automatic launch(input logic [N-1:0] t, input int inj, input bit poke);
    int n = 0;
    trial_log.delete();
    target = t;
    inj_cur = inj;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0 && n < 40) begin
      start = (poke && $urandom_range(0, 2) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL launch_timeout actual=timeout expected=done at %0t", $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    #1;
    // Pin the model with hand-derived sequences.
    held_r = '0;
    build(4'd5, 0);
    chk("pin5_len", 32'(exp_q.size()), 32'd5);
    chk("pin5_t0", 32'(exp_q[0][2*N-1:N]), 32'd8);
    chk("pin5_t1", 32'(exp_q[1][2*N-1:N]), 32'd4);
    chk("pin5_t2", 32'(exp_q[2][2*N-1:N]), 32'd6);
    chk("pin5_t3", 32'(exp_q[3][2*N-1:N]), 32'd5);
    chk("pin5_res", 32'(exp_q[4][N-1:0]), 32'd5);
    exp_q.delete();
    build(4'd8, 0);
    chk("pin8_len", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    build(4'd0, 0);
    chk("pin0_len", 32'(exp_q.size()), 32'd5);
    chk("pin0_t3", 32'(exp_q[3][2*N-1:N]), 32'd1);
    chk("pin0_res", 32'(exp_q[4][N-1:0]), 32'd0);
    exp_q.delete();
    build(4'd15, 0);
    chk("pin15_len", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    build(4'd13, 2);
    chk("pin13inj_len", 32'(exp_q.size()), 32'd3);
    chk("pin13inj_res", 32'(exp_q[2][N-1:0]), 32'd8);
    chk("pin13inj_err", 32'(exp_q[2][2*N]), 32'd1);
    exp_q.delete();
    exp_k = 0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed target 5: trial sequence seen on the DUT.
    launch(4'd5, 0, 1'b0);
    chk("t5_ntrials", 32'(trial_log.size()), 32'd4);
    if (trial_log.size() == 4) begin
      chk("t5_trial0", 32'(trial_log[0]), 32'd8);
      chk("t5_trial1", 32'(trial_log[1]), 32'd4);
      chk("t5_trial2", 32'(trial_log[2]), 32'd6);
      chk("t5_trial3", 32'(trial_log[3]), 32'd5);
    end

    // Exhaustive targets.
    for (int t = 0; t < 16; t++) launch(t[N-1:0], 0, 1'b0);

    // Inconsistent flags on the 2nd run cycle, then a clean search.
    launch(4'd13, 2, 1'b0);
    chk("inj_err_held", 32'(err), 32'd1);
    launch(4'd6, 0, 1'b0);
    chk("inj_err_cleared", 32'(err), 32'd0);

    // Reset in the 3rd run cycle.
    trial_log.delete();
    target = 4'd11;
    inj_cur = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 10 && !(exp_q.size() > 0 && int'(exp_q[0][W-1:W-3]) == 3); n++)
      @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_trial", 32'(trial), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(4'd7, 0, 1'b0);

    // Start held high: back-to-back searches, start ignored in run/done.
    target = 4'd9;
    inj_cur = 0;
    start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Random targets, random fault injection, random start pokes.
    for (int r = 0; r < 40; r++) begin
      int inj;
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0;
      launch(4'($urandom_range(0, 15)), inj, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
